// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared widths, latencies and record types for the instruction fetch sequencer.
package inst_fetch_ctrl_pkg;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;
  localparam int ROM_LAT = 2;
  localparam int FIFO_D  = 3;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  localparam int CNT_W  = $clog2(FIFO_D + 1);
  localparam int CRED_W = $clog2(FIFO_D + ROM_LAT + 1);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
  } tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  function automatic logic [CRED_W-1:0] count_ones(input logic [ROM_LAT-1:0] v);
    logic [CRED_W-1:0] n;
    n = '0;
    for (int i = 0; i < ROM_LAT; i++) n = n + CRED_W'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Return buffer between the non-stallable ROM and decode; flush drops all entries.
module fetch_fifo
  import inst_fetch_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  input  logic             flush,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;

  entry_t           mem [FIFO_D];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_D; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the PC, tags fixed-latency ROM reads, buffers returns
// and hands instructions to decode; redirects squash every older fetch.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);
  logic [ADDR_W-1:0]  pc;
  tag_t               tag [ROM_LAT];
  logic [ROM_LAT-1:0] tag_valid;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [CRED_W-1:0]  credit;
  logic               pop;
  logic               issue;
  logic               push;
  entry_t             head;

  always_comb begin
    tag_valid = '0;
    for (int i = 0; i < ROM_LAT; i++) tag_valid[i] = tag[i].valid;
  end

  // Every in-flight read owns a FIFO slot in advance, so the ROM never needs to stall.
  assign pop      = inst_valid & inst_ready;
  assign credit   = count_ones(tag_valid) + CRED_W'(fifo_cnt) - CRED_W'(pop);
  assign issue    = redirect_valid | (credit < CRED_W'(FIFO_D));
  assign rom_addr = redirect_valid ? redirect_pc : pc;
  assign push     = tag[ROM_LAT-1].valid;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc <= RESET_PC;
      for (int i = 0; i < ROM_LAT; i++) tag[i] <= '0;
    end else begin
      tag[0] <= tag_t'{valid: issue, pc: rom_addr};
      for (int i = 1; i < ROM_LAT; i++) tag[i] <= redirect_valid ? tag_t'('0) : tag[i-1];
      if (issue) pc <= rom_addr + ADDR_W'(1);
    end
  end

  fetch_fifo u_fifo (
    .clock      (clock),
    .resetn     (resetn),
    .push       (push),
    .push_entry (entry_t'{data: rom_q, pc: tag[ROM_LAT-1].pc}),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (fifo_cnt)
  );

  assign inst_valid = (fifo_cnt != '0);
  assign inst_data  = head.data;
  assign inst_pc    = head.pc;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed cycle table, scoreboarded random traffic,
// stall, redirect and mid-stream reset sequences against a 2-clock ROM model.
`timescale 1ns/1ps
module tb_inst_fetch_ctrl;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  rom_addr;
  logic [31:0] rom_q = '0;
  logic        redirect_valid = 1'b0;
  logic [3:0]  redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [3:0]  inst_pc;

  inst_fetch_ctrl dut (
    .clock          (clock),
    .resetn         (resetn),
    .rom_addr       (rom_addr),
    .rom_q          (rom_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clock = ~clock;

  // ROM: address register then output register, mem[i] = A000_0000 + i
  logic [3:0] rom_a = '0;
  always @(posedge clock) begin
    rom_a <= rom_addr;
    rom_q <= 32'hA000_0000 + {28'd0, rom_a};
  end

  typedef struct {
    logic       rdy;
    logic       rv;
    logic [3:0] rpc;
    logic       ev;
    logic [3:0] epc;
    logic [3:0] eaddr;
  } vec_t;

  vec_t vecs [22];

  int tests = 0;
  int fails = 0;

  logic [3:0]  exp_next = '0;
  logic        hold_pending = 1'b0;
  logic [3:0]  held_pc = '0;
  logic [31:0] held_data = '0;
  int          gap = 0;
  int          hs_count = 0;

  function automatic vec_t mk(bit rdy, bit rv, int rpc, bit ev, int epc, int eaddr);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = 4'(rpc);
    v.ev = ev; v.epc = 4'(epc); v.eaddr = 4'(eaddr);
    return v;
  endfunction

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_reset();
    exp_next = '0;
    hold_pending = 1'b0;
    gap = 0;
  endtask

  // One clock of traffic, checked against the transaction-level model.
  task automatic step(input logic rdy, input logic rv, input logic [3:0] rpc);
    inst_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    @(negedge clock);
    if (hold_pending)
      check(inst_valid && inst_pc == held_pc && inst_data == held_data, "hold_stable",
            {inst_valid, inst_pc}, {1'b1, held_pc});
    if (inst_valid && rdy) begin
      check(inst_pc == exp_next, "seq_pc", inst_pc, exp_next);
      check(inst_data == 32'hA000_0000 + {28'd0, exp_next}, "seq_data", inst_data,
            32'hA000_0000 + {28'd0, exp_next});
      exp_next = exp_next + 4'd1;
      hs_count++;
    end
    check(!(dut.push && dut.fifo_cnt == 2'd3 && !(inst_valid && rdy) && !rv), "fifo_overflow",
          dut.fifo_cnt, 3);
    if (rv) exp_next = rpc;
    gap = (rv || inst_valid) ? 0 : gap + 1;
    check(gap <= 3, "valid_gap", gap, 3);
    hold_pending = inst_valid && !rdy && !rv;
    held_pc = inst_pc;
    held_data = inst_data;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_before;
    logic [3:0] addr_snap;

    vecs[0]  = mk(1, 0, 0,  0, 0,  0);
    vecs[1]  = mk(1, 0, 0,  0, 0,  1);
    vecs[2]  = mk(1, 0, 0,  0, 0,  2);
    vecs[3]  = mk(1, 0, 0,  1, 0,  3);
    vecs[4]  = mk(1, 0, 0,  1, 1,  4);
    vecs[5]  = mk(1, 0, 0,  1, 2,  5);
    vecs[6]  = mk(0, 0, 0,  1, 3,  6);
    vecs[7]  = mk(0, 0, 0,  1, 3,  6);
    vecs[8]  = mk(0, 0, 0,  1, 3,  6);
    vecs[9]  = mk(0, 0, 0,  1, 3,  6);
    vecs[10] = mk(1, 0, 0,  1, 3,  6);
    vecs[11] = mk(1, 0, 0,  1, 4,  7);
    vecs[12] = mk(1, 0, 0,  1, 5,  8);
    vecs[13] = mk(1, 0, 0,  1, 6,  9);
    vecs[14] = mk(1, 1, 12, 1, 7,  12);
    vecs[15] = mk(1, 0, 0,  0, 0,  13);
    vecs[16] = mk(1, 0, 0,  0, 0,  14);
    vecs[17] = mk(1, 0, 0,  1, 12, 15);
    vecs[18] = mk(1, 0, 0,  1, 13, 0);
    vecs[19] = mk(1, 0, 0,  1, 14, 1);
    vecs[20] = mk(1, 0, 0,  1, 15, 2);
    vecs[21] = mk(1, 0, 0,  1, 0,  3);

    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;

    for (int i = 0; i < 22; i++) begin
      inst_ready = vecs[i].rdy; redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      @(negedge clock);
      check(inst_valid == vecs[i].ev, $sformatf("tbl%0d_valid", i), inst_valid, vecs[i].ev);
      check(rom_addr == vecs[i].eaddr, $sformatf("tbl%0d_addr", i), rom_addr, vecs[i].eaddr);
      if (vecs[i].ev) begin
        check(inst_pc == vecs[i].epc, $sformatf("tbl%0d_pc", i), inst_pc, vecs[i].epc);
        check(inst_data == 32'hA000_0000 + {28'd0, vecs[i].epc}, $sformatf("tbl%0d_data", i),
              inst_data, 32'hA000_0000 + {28'd0, vecs[i].epc});
      end
      if (i == 0) begin
        check(inst_data == 32'd0, "reset_data", inst_data, 0);
        check(inst_pc == 4'd0, "reset_pc", inst_pc, 0);
      end
      @(posedge clock);
      #1;
    end

    // table ended with a handshake of pc 0 while streaming
    sb_reset();
    exp_next = 4'd1;

    // long ready=0 stall: head held, FIFO fills, issue stops
    repeat (3) step(1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 4'd0);
      if (i == 2) addr_snap = rom_addr;
    end
    check(rom_addr == addr_snap, "stall_issue_stops", rom_addr, addr_snap);
    check(dut.fifo_cnt == 2'd3, "stall_fifo_full", dut.fifo_cnt, 3);
    repeat (6) step(1'b1, 1'b0, 4'd0);

    // redirect with reads in flight and FIFO non-empty
    step(1'b1, 1'b1, 4'd9);
    check(inst_valid == 1'b0, "redirect_flush", inst_valid, 0);
    hs_before = hs_count;
    repeat (4) step(1'b1, 1'b0, 4'd0);
    check(hs_count - hs_before == 2, "redirect_restart", hs_count - hs_before, 2);

    // back-to-back redirects: only the later target is delivered
    step(1'b1, 1'b1, 4'd3);
    step(1'b1, 1'b1, 4'd14);
    repeat (6) step(1'b1, 1'b0, 4'd0);

    // asynchronous reset mid-stream
    resetn = 1'b0;
    #2;
    check(inst_valid == 1'b0, "async_rst_valid", inst_valid, 0);
    check(inst_data == 32'd0, "async_rst_data", inst_data, 0);
    check(inst_pc == 4'd0, "async_rst_pc", inst_pc, 0);
    check(rom_addr == 4'd0, "async_rst_addr", rom_addr, 0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    sb_reset();
    hs_before = hs_count;
    repeat (4) step(1'b1, 1'b0, 4'd0);
    check(hs_count - hs_before == 1, "post_reset_first", hs_count - hs_before, 1);

    // randomized traffic against the scoreboard
    hs_before = hs_count;
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 4'($urandom_range(0, 15)));
    check(hs_count - hs_before >= 100, "random_progress", hs_count - hs_before, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
